// File: rtl/load_store_unit_if.sv
// load_store_unit_if: core request/response and SDRAM data-port bundle for the load/store unit
interface load_store_unit_if #(parameter int ADDR_W = 25);
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [4:0]        req_rd;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic [4:0]        resp_rd;
    logic              resp_we;
    logic              resp_misaligned;
    logic              resp_fault;
    logic              mem_enable;
    logic              mem_valid;
    logic              mem_rw;
    logic [1:0]        mem_oplen;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd, mem_valid, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_rd, resp_we, resp_misaligned, resp_fault,
               mem_enable, mem_rw, mem_oplen, mem_addr, mem_wdata
    );
    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd, mem_valid, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_rd, resp_we, resp_misaligned, resp_fault,
               mem_enable, mem_rw, mem_oplen, mem_addr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store execution against the SDRAM data port, one request at a time
module load_store_unit #(
    parameter int ADDR_W  = 25,
    parameter int TIMEOUT = 1024
) (
    input logic clk,
    input logic rst_n,
    load_store_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CHECK, ACCESS, RESP} state_e;
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
    state_e state_q, state_d;
    logic store_q, store_d;
    logic [2:0] funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0] rd_q, rd_d;
    logic [31:0] rdata_q, rdata_d;
    logic mis_q, mis_d;
    logic fault_q, fault_d;
    logic mem_en_q, mem_en_d;
    logic mem_rw_q, mem_rw_d;
    logic [1:0] oplen_q, oplen_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic accept, bad_f3, misal, out_range, start, mem_done, timed_out, resp, ok_load;
    logic [31:0] ext;
    assign accept    = state_q == IDLE && bus.req_valid;
    assign bad_f3    = funct3_q inside {3'b011, 3'b110, 3'b111} || (store_q && funct3_q[2]);
    assign misal     = !bad_f3 && ((funct3_q[1:0] == 2'b01 && addr_q[0]) ||
                                   (funct3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00));
    assign out_range = !bad_f3 && !misal && addr_q[31:ADDR_W] != '0;
    assign start     = state_q == CHECK && !bad_f3 && !misal && !out_range;
    assign mem_done  = state_q == ACCESS && bus.mem_valid;
    // a completion in the expiry cycle wins over the timeout
    assign timed_out = state_q == ACCESS && !bus.mem_valid && TIMEOUT != 0 && cnt_q == CNT_LAST;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            store_q     <= 1'b0;
            funct3_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_q        <= '0;
            rdata_q     <= '0;
            mis_q       <= 1'b0;
            fault_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_rw_q    <= 1'b1;
            oplen_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            store_q     <= store_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_q        <= rd_d;
            rdata_q     <= rdata_d;
            mis_q       <= mis_d;
            fault_q     <= fault_d;
            mem_en_q    <= mem_en_d;
            mem_rw_q    <= mem_rw_d;
            oplen_q     <= oplen_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cnt_q       <= cnt_d;
        end
    end
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = accept ? CHECK : IDLE;
            CHECK:   state_d = start ? ACCESS : RESP;
            ACCESS:  state_d = (mem_done || timed_out) ? RESP : ACCESS;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        store_d     = accept ? bus.req_store : store_q;
        funct3_d    = accept ? bus.req_funct3 : funct3_q;
        addr_d      = accept ? bus.req_addr : addr_q;
        wdata_d     = accept ? bus.req_wdata : wdata_q;
        rd_d        = accept ? bus.req_rd : rd_q;
        rdata_d     = mem_done ? bus.mem_rdata : rdata_q;
        mis_d       = accept ? 1'b0 : state_q == CHECK ? misal : mis_q;
        fault_d     = accept ? 1'b0 : state_q == CHECK ? (bad_f3 || out_range) : (timed_out || fault_q);
        mem_en_d    = start ? 1'b1 : (mem_done || timed_out) ? 1'b0 : mem_en_q;
        mem_rw_d    = start ? !store_q : mem_rw_q;
        oplen_d     = start ? funct3_q[1:0] : oplen_q;
        mem_addr_d  = start ? addr_q[ADDR_W-1:0] : mem_addr_q;
        mem_wdata_d = !start ? mem_wdata_q :
                      funct3_q[1:0] == 2'b00 ? {24'b0, wdata_q[7:0]} :
                      funct3_q[1:0] == 2'b01 ? {16'b0, wdata_q[15:0]} : wdata_q;
        cnt_d       = start ? '0 : state_q == ACCESS ? cnt_q + 1'b1 : cnt_q;
    end
    always_comb begin
        resp    = state_q == RESP;
        ok_load = resp && !store_q && !mis_q && !fault_q;
        ext     = funct3_q == 3'b000 ? {{24{rdata_q[7]}}, rdata_q[7:0]} :
                  funct3_q == 3'b100 ? {24'b0, rdata_q[7:0]} :
                  funct3_q == 3'b001 ? {{16{rdata_q[15]}}, rdata_q[15:0]} :
                  funct3_q == 3'b101 ? {16'b0, rdata_q[15:0]} : rdata_q;
        bus.req_ready       = state_q == IDLE;
        bus.resp_valid      = resp;
        bus.resp_rdata      = ok_load ? ext : '0;
        bus.resp_rd         = resp ? rd_q : '0;
        bus.resp_we         = ok_load && rd_q != '0;
        bus.resp_misaligned = resp && mis_q;
        bus.resp_fault      = resp && fault_q;
        bus.mem_enable      = mem_en_q;
        bus.mem_rw          = mem_rw_q;
        bus.mem_oplen       = oplen_q;
        bus.mem_addr        = mem_addr_q;
        bus.mem_wdata       = mem_wdata_q;
    end
endmodule
